// File: rtl/vga_rect_scheduler.sv
// Per-pixel rectangle hit resolver with a CPU shadow table that is published to
// the active table only during vertical blank, one slot per cycle.
module vga_rect_scheduler #(
    parameter int NUM_RECTS = 4,
    parameter int IDX_W     = 2,
    parameter int COLOR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [2:0]         wr_field,
    input  logic [10:0]        wr_data,
    input  logic               commit,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [10:0]        x,
    input  logic [10:0]        y,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic [COLOR_W-1:0] color_out,
    output logic               commit_pending,
    output logic               busy
);

    typedef struct packed {
        logic [10:0]        cx;
        logic [10:0]        cy;
        logic [10:0]        w;
        logic [10:0]        h;
        logic [COLOR_W-1:0] color;
        logic               en;
    } rect_t;

    typedef enum logic {IDLE, COPY} state_t;

    rect_t              shadow_q [NUM_RECTS];
    rect_t              shadow_d [NUM_RECTS];
    rect_t              active_q [NUM_RECTS];
    rect_t              active_d [NUM_RECTS];
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COLOR_W-1:0] col_q, col_d;

    // 12-bit math keeps centre +/- half-size from wrapping, so edges clip.
    function automatic logic covers(input rect_t r, input logic [10:0] px, input logic [10:0] py);
        logic [11:0] hw, hh;
        logic        in_x, in_y;
        hw   = {1'b0, r.w} >> 1;
        hh   = {1'b0, r.h} >> 1;
        in_x = (({1'b0, px} + hw) > {1'b0, r.cx}) && ({1'b0, px} < ({1'b0, r.cx} + hw));
        in_y = (({1'b0, py} + hh) > {1'b0, r.cy}) && ({1'b0, py} < ({1'b0, r.cy} + hh));
        return r.en && in_x && in_y;
    endfunction

    assign busy = (state_q == COPY);

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en && !busy) begin
            case (wr_field)
                3'd0:    shadow_d[wr_idx].cx    = wr_data;
                3'd1:    shadow_d[wr_idx].cy    = wr_data;
                3'd2:    shadow_d[wr_idx].w     = wr_data;
                3'd3:    shadow_d[wr_idx].h     = wr_data;
                3'd4:    shadow_d[wr_idx].color = wr_data[COLOR_W-1:0];
                3'd5:    shadow_d[wr_idx].en    = wr_data[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q | commit;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                if (frame_start && (pend_q || commit)) begin
                    state_d = COPY;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            COPY: begin
                // Shadow is frozen while busy, so slots copy from a stable source.
                active_d[cnt_q] = shadow_q[cnt_q];
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(NUM_RECTS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        col_d = '0;
        if (pix_valid && !busy) begin
            // Walk downward so the lowest covering index is the one left standing.
            for (int i = NUM_RECTS - 1; i >= 0; i--) begin
                if (covers(active_q[i], x, y)) begin
                    hit_d = 1'b1;
                    idx_d = IDX_W'(i);
                    col_d = active_q[i].color;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            col_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            hit_q    <= hit_d;
            idx_q    <= idx_d;
            col_q    <= col_d;
        end
    end

    assign hit            = hit_q;
    assign hit_idx        = idx_q;
    assign color_out      = col_q;
    assign commit_pending = pend_q;

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// Directed bench for vga_rect_scheduler: hit geometry, priority, shadow/active
// isolation, copy timing and reset/busy corner cases.
module tb_vga_rect_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [2:0]  wr_field;
    logic [10:0] wr_data;
    logic        commit, frame_start, pix_valid;
    logic [10:0] x, y;
    logic        hit;
    logic [1:0]  hit_idx;
    logic [7:0]  color_out;
    logic        commit_pending, busy;

    int total = 0;
    int bad   = 0;

    vga_rect_scheduler #(.NUM_RECTS(4), .IDX_W(2), .COLOR_W(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_field(wr_field),
        .wr_data(wr_data), .commit(commit), .frame_start(frame_start),
        .pix_valid(pix_valid), .x(x), .y(y), .hit(hit), .hit_idx(hit_idx),
        .color_out(color_out), .commit_pending(commit_pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [2:0] f, input logic [10:0] d);
        wr_en = 1'b1; wr_idx = idx; wr_field = f; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic set_rect(input logic [1:0] idx, input int cx, input int cy, input int w,
                            input int h, input logic [7:0] col, input logic en);
        wr(idx, 3'd0, 11'(cx));
        wr(idx, 3'd1, 11'(cy));
        wr(idx, 3'd2, 11'(w));
        wr(idx, 3'd3, 11'(h));
        wr(idx, 3'd4, {3'b0, col});
        wr(idx, 3'd5, {10'b0, en});
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    // Pulses frame_start and returns how many sampled cycles busy stayed high.
    task automatic do_frame(output int n);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic pix(input int px, input int py, output logic h, output logic [1:0] i,
                       output logic [7:0] c);
        pix_valid = 1'b1; x = 11'(px); y = 11'(py);
        step();
        pix_valid = 1'b0;
        h = hit; i = hit_idx; c = color_out;
    endtask

    task automatic test_reset();
        logic h; logic [1:0] i; logic [7:0] c;
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        pix(100, 100, h, i, c);
        total++;
        if ({h, i, c, busy, commit_pending} !== 13'b0) begin
            $display("FAIL reset_state got hit=%b idx=%0d col=%h busy=%b pend=%b want all 0",
                     h, i, c, busy, commit_pending);
            bad++;
        end
    endtask

    task automatic test_basic();
        int n; logic h; logic [1:0] i; logic [7:0] c;
        int          px [7]   = '{91, 90, 109, 110, 100, 100, 100};
        int          py [7]   = '{50, 50, 50, 50, 46, 45, 54};
        logic        eh [7]   = '{1, 0, 1, 0, 1, 0, 1};
        set_rect(2'd0, 100, 50, 20, 10, 8'hA5, 1'b1);
        do_commit();
        total++;
        if (commit_pending !== 1'b1) begin
            $display("FAIL commit_pending got %b want 1", commit_pending); bad++;
        end
        do_frame(n);
        total++;
        if (n != 4) begin $display("FAIL busy_cycles got %0d want 4", n); bad++; end
        total++;
        if (commit_pending !== 1'b0) begin
            $display("FAIL pending_after_copy got %b want 0", commit_pending); bad++;
        end
        for (int k = 0; k < 7; k++) begin
            pix(px[k], py[k], h, i, c);
            total++;
            if (h !== eh[k] || i !== 2'd0 || c !== (eh[k] ? 8'hA5 : 8'h00)) begin
                $display("FAIL basic_edge x=%0d y=%0d got hit=%b idx=%0d col=%h want hit=%b",
                         px[k], py[k], h, i, c, eh[k]);
                bad++;
            end
        end
    endtask

    task automatic test_overlap();
        int n; logic h; logic [1:0] i; logic [7:0] c;
        set_rect(2'd1, 100, 50, 40, 40, 8'h3C, 1'b1);
        do_commit();
        do_frame(n);
        pix(100, 50, h, i, c);
        total++;
        if ({h, i, c} !== {1'b1, 2'd0, 8'hA5}) begin
            $display("FAIL overlap_prio got hit=%b idx=%0d col=%h want 1/0/a5", h, i, c); bad++;
        end
        pix(85, 50, h, i, c);
        total++;
        if ({h, i, c} !== {1'b1, 2'd1, 8'h3C}) begin
            $display("FAIL overlap_slot1 got hit=%b idx=%0d col=%h want 1/1/3c", h, i, c); bad++;
        end
    endtask

    task automatic test_shadow_iso();
        int n; logic h; logic [1:0] i; logic [7:0] c;
        wr(2'd0, 3'd4, 11'h011);
        do_frame(n);
        total++;
        if (n != 0) begin $display("FAIL no_commit_copy busy=%0d want 0", n); bad++; end
        pix(100, 50, h, i, c);
        total++;
        if (c !== 8'hA5) begin $display("FAIL shadow_iso got col=%h want a5", c); bad++; end
        do_commit();
        do_frame(n);
        pix(100, 50, h, i, c);
        total++;
        if (c !== 8'h11) begin $display("FAIL shadow_publish got col=%h want 11", c); bad++; end
    endtask

    task automatic test_disable();
        int n; logic h; logic [1:0] i; logic [7:0] c;
        wr(2'd0, 3'd5, 11'd0);
        do_commit();
        do_frame(n);
        pix(100, 50, h, i, c);
        total++;
        if ({h, i, c} !== {1'b1, 2'd1, 8'h3C}) begin
            $display("FAIL disable_slot0 got hit=%b idx=%0d col=%h want 1/1/3c", h, i, c); bad++;
        end
    endtask

    task automatic test_edge_clip();
        int n; logic h; logic [1:0] i; logic [7:0] c;
        int   px [4] = '{0, 12, 13, 2040};
        logic eh [4] = '{1, 1, 0, 0};
        set_rect(2'd2, 3, 50, 20, 10, 8'h77, 1'b1);
        do_commit();
        do_frame(n);
        for (int k = 0; k < 4; k++) begin
            pix(px[k], 50, h, i, c);
            total++;
            if (h !== eh[k] || c !== (eh[k] ? 8'h77 : 8'h00) || i !== (eh[k] ? 2'd2 : 2'd0)) begin
                $display("FAIL edge_clip x=%0d got hit=%b idx=%0d col=%h want hit=%b",
                         px[k], h, i, c, eh[k]);
                bad++;
            end
        end
    endtask

    task automatic test_simul();
        int n; logic h; logic [1:0] i; logic [7:0] c;
        wr(2'd1, 3'd4, 11'h042);
        commit = 1'b1; frame_start = 1'b1;
        step();
        commit = 1'b0; frame_start = 1'b0;
        total++;
        if (commit_pending !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL commit_frame_same got pend=%b busy=%b want 0/1", commit_pending, busy);
            bad++;
        end
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        pix(100, 50, h, i, c);
        total++;
        if ({h, i, c} !== {1'b1, 2'd1, 8'h42}) begin
            $display("FAIL simul_copy got hit=%b idx=%0d col=%h want 1/1/42", h, i, c); bad++;
        end
    endtask

    task automatic test_busy();
        int n; logic h; logic [1:0] i; logic [7:0] c;
        do_commit();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        // First COPY cycle: write and commit both arrive while busy.
        wr_en = 1'b1; wr_idx = 2'd1; wr_field = 3'd4; wr_data = 11'h0EE;
        commit = 1'b1; pix_valid = 1'b1; x = 11'd100; y = 11'd50;
        step();
        wr_en = 1'b0; commit = 1'b0; pix_valid = 1'b0;
        total++;
        if (hit !== 1'b0 || color_out !== 8'h00) begin
            $display("FAIL hit_while_busy got hit=%b col=%h want 0/00", hit, color_out); bad++;
        end
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        total++;
        if (busy !== 1'b0 || commit_pending !== 1'b1) begin
            $display("FAIL commit_during_copy got busy=%b pend=%b want 0/1", busy, commit_pending);
            bad++;
        end
        pix(100, 50, h, i, c);
        total++;
        if (c !== 8'h42) begin $display("FAIL write_dropped got col=%h want 42", c); bad++; end
    endtask

    task automatic test_reset_mid();
        int n; logic h; logic [1:0] i; logic [7:0] c;
        pix_valid = 1'b1; x = 11'd100; y = 11'd50;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({hit, hit_idx, color_out, busy, commit_pending} !== 13'b0) begin
            $display("FAIL reset_mid_copy got hit=%b idx=%0d col=%h busy=%b pend=%b want all 0",
                     hit, hit_idx, color_out, busy, commit_pending);
            bad++;
        end
        pix_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        pix(100, 50, h, i, c);
        total++;
        if ({h, i, c} !== 11'b0) begin
            $display("FAIL after_reset_miss got hit=%b idx=%0d col=%h want 0", h, i, c); bad++;
        end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_field = '0; wr_data = '0;
        commit = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; x = '0; y = '0;
        test_reset();
        test_basic();
        test_overlap();
        test_shadow_iso();
        test_disable();
        test_edge_clip();
        test_simul();
        test_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_rect_scheduler.md
Name: vga_rect_scheduler

Overview:
- Owns a table of NUM_RECTS rectangle descriptors: centre, size, colour, enable.
- Resolves, per pixel, which rectangle (if any) covers the current VGA beam position, lowest index winning.
- The CPU writes a shadow table at any time; the shadow is copied to the active table only during vertical blank after a commit, so frames never tear.
- Sits between the VGA timing generator and the pixel colour mux.

Parameters:
- NUM_RECTS, 4, number of descriptor slots (power of two, 2..8).
- IDX_W, 2, log2(NUM_RECTS).
- COLOR_W, 8, width of per-rect colour.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  shadow write strobe.
- wr_idx  in  IDX_W  slot being written.
- wr_field  in  3  0=center_x, 1=center_y, 2=width, 3=height, 4=color (wr_data[COLOR_W-1:0]), 5=enable (wr_data[0]); 6,7 ignored.
- wr_data  in  11  write data.
- commit  in  1  one-cycle request to publish the shadow table.
- frame_start  in  1  one-cycle pulse at the first vertical-blank cycle.
- pix_valid  in  1  x/y is a visible pixel this cycle.
- x, y  in  11 each  current beam position.
- hit  out  1  a rectangle covers the pixel.
- hit_idx  out  IDX_W  winning slot.
- color_out  out  COLOR_W  winning colour, 0 if no hit.
- commit_pending  out  1  commit accepted, copy not yet done.
- busy  out  1  copy in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - All shadow and active fields cleared to 0, including enable.
  - hit, hit_idx, color_out, commit_pending, busy all 0.
  - FSM goes to IDLE, copy counter to 0.
- Shadow writes:
  - When wr_en=1 and busy=0, the addressed field updates at the clock edge.
  - When busy=1, wr_en is ignored (write dropped).
  - Writes never affect the active table directly.
- commit: sets commit_pending the next cycle. Repeated commits are idempotent.
- FSM states:
  - IDLE: on frame_start with (commit_pending=1 or commit=1), go to COPY. Clear counter and commit_pending; busy=1 from the next cycle.
  - COPY: one slot per cycle, active[cnt] <= shadow[cnt], cnt++. After slot NUM_RECTS-1, return to IDLE. busy deasserts the cycle after the last copy, so COPY lasts exactly NUM_RECTS cycles.
  - A commit arriving during COPY sets commit_pending again; it takes effect at the next frame_start, not this one.
  - frame_start while already in COPY is ignored.
- Hit test, slot i, using the active table only:
  - All arithmetic is 12-bit unsigned. half_w = width>>1, half_h = height>>1.
  - in_x = (x + half_w > center_x) and (x < center_x + half_w).
  - in_y uses y, center_y and half_h in the same way.
  - Inequalities are strict, so a rect with width<=1 or height<=1 never shows.
  - No wrap-around: a rect that extends past 0 or 2047 is clipped.
  - cover_i = enable_i and in_x and in_y.
- Output pipeline: exactly 1 cycle latency, all outputs registered.
  - The cycle after pix_valid=1: hit = OR of cover_i; hit_idx = lowest i with cover_i=1; color_out = color of that slot.
  - If pix_valid=0, no cover, or busy=1: hit=0, hit_idx=0, color_out=0 the next cycle.
- Simultaneous events:
  - commit and frame_start in the same cycle from IDLE: the copy starts immediately; commit_pending never visibly rises.
  - A write and commit in the same cycle: the write lands before any later copy.
- Reset mid-COPY: the active table is cleared; the partial copy is discarded.

Test Plan:
- Reset, then pix_valid=1 at x=100, y=100 -> hit=0, color_out=0; busy=0, commit_pending=0.
- Program slot0 (cx=100, cy=50, w=20, h=10, color=8'hA5, en=1), commit, then frame_start:
  - busy high for exactly 4 cycles.
  - Next, x=91, y=50 -> hit=1, idx=0, color A5 one cycle later.
  - x=90 -> hit=0; x=109 -> hit=1; x=110 -> hit=0; y=46 -> hit=1; y=45 -> hit=0.
- Overlap: slot1 (cx=100, cy=50, w=40, h=40, color=8'h3C) plus slot0 above, committed:
  - x=100, y=50 -> idx=0, A5.
  - x=85, y=50 -> idx=1, 3C.
  - Disable slot0, commit, frame_start -> x=100, y=50 gives idx=1.
- Shadow isolation: change slot0 color to 8'h11 without commit; frame_start -> color stays A5. Then commit -> next frame_start shows 11.
- Edge clip: cx=3, w=20, cy=50, h=10 -> x=0 hits; x=12 hits; x=13 misses; no hit at x=2040.
- Busy/reset corners:
  - wr_en during COPY is dropped (readback via hit test shows the old value).
  - commit during COPY leaves commit_pending=1 after busy falls.
  - rst low mid-COPY -> all outputs 0; a subsequent hit test misses.
